// File: rtl/pucch_alpha_scheduler.sv
// pucch_alpha_scheduler: per-slot sequencer for the PUCCH cyclic-shift alpha
// generator. Accepts one occasion config, pulls one alpha per symbol from the
// generator, drops alphas of symbols before the start symbol, and streams the
// remaining alphas (tagged with symbol index) to the sequence-rotation stage.
//
// Optional feature macro: PUCCH_ALPHA_SCHED_ABORT_EN adds input i_abort, which
// returns the block to IDLE from any busy state and flushes the output buffer.
//
// Stream handshake: a beat transfers on a rising clk edge where
// o_valid && i_ready; o_alpha/o_sym_idx/o_last hold while o_valid && !i_ready.
// Config transfers where i_cfg_valid && o_cfg_ready. Generator gets transfer
// on every edge where o_gen_get is high; the generator returns values in
// request order on i_gen_valid, never in the same cycle as the request.
`timescale 1ns/1ps

module pucch_alpha_scheduler #(
    parameter int FIFO_DEPTH = 2,
    parameter int NSYM_SLOT  = 14
) (
    input  logic        clk,
    input  logic        rst,
`ifdef PUCCH_ALPHA_SCHED_ABORT_EN
    input  logic        i_abort,
`endif
    input  logic        i_cfg_valid,
    output logic        o_cfg_ready,
    input  logic [3:0]  i_m0,
    input  logic [3:0]  i_mcs,
    input  logic [7:0]  i_nslot,
    input  logic [9:0]  i_nid,
    input  logic [3:0]  i_start_sym,
    input  logic [3:0]  i_nsym,
    output logic        o_gen_start,
    output logic [3:0]  o_gen_m0,
    output logic [3:0]  o_gen_mcs,
    output logic [7:0]  o_gen_nslot,
    output logic [9:0]  o_gen_nid,
    output logic        o_gen_get,
    input  logic        i_gen_can_get,
    input  logic        i_gen_valid,
    input  logic [4:0]  i_gen_alpha,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [4:0]  o_alpha,
    output logic [3:0]  o_sym_idx,
    output logic        o_last,
    output logic        o_done,
    output logic        o_err,
    output logic [1:0]  o_dbg_state
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [5:0] DEPTH6 = 6'(FIFO_DEPTH);
    localparam logic [4:0] NSYM5  = 5'(NSYM_SLOT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_RUN   = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t       state;

    // Occasion bookkeeping
    logic [3:0]   start_sym_q;
    logic [4:0]   total_q;      // start_sym + nsym = number of gets
    logic [4:0]   gets_q;       // gets issued this occasion
    logic [4:0]   recv_q;       // values received this occasion
    logic [4:0]   drop_q;       // stale values still owed by the generator

    // Pulse outputs
    logic         start_q;
    logic         err_q;
    logic         done_q;

    // Output buffer: entry = {alpha[4:0], sym_idx[3:0], last}
    logic [9:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count_q;

    logic         abort_req;
    logic         flush;
    logic         cfg_accept;
    logic [4:0]   cfg_sum;
    logic         cfg_bad;
    logic [4:0]   inflight;
    logic [5:0]   credit_sum;
    logic         gen_get;
    logic         drop_hit;
    logic         recv;
    logic         push;
    logic         push_last;
    logic         pop;
    logic [9:0]   head;
    logic         pop_last;

`ifdef PUCCH_ALPHA_SCHED_ABORT_EN
    assign abort_req = i_abort;
`else
    assign abort_req = 1'b0;
`endif

    // Handshake, credit and receive qualification
    always_comb begin
        flush      = abort_req && (state != S_IDLE);
        cfg_accept = i_cfg_valid && (state == S_IDLE);
        cfg_sum    = {1'b0, i_start_sym} + {1'b0, i_nsym};
        cfg_bad    = (i_nsym == 4'd0) || (cfg_sum > NSYM5);
        inflight   = gets_q - recv_q;
        credit_sum = 6'(count_q) + {1'b0, inflight};
        // Buffer slots are reserved at get time, so a push never meets a full FIFO.
        gen_get    = (state == S_RUN) && i_gen_can_get && (gets_q < total_q)
                     && (credit_sum < DEPTH6);
        // Values still owed from an aborted occasion arrive first and are eaten.
        drop_hit   = i_gen_valid && (drop_q != 5'd0);
        recv       = i_gen_valid && !drop_hit && (inflight != 5'd0);
        push       = recv && (recv_q >= {1'b0, start_sym_q}) && !flush;
        push_last  = (recv_q == (total_q - 5'd1));
        head       = mem[rd_ptr];
        pop        = (count_q != '0) && i_ready;
        pop_last   = pop && head[0];
    end

    // Occasion FSM, counters and registered pulse outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            start_sym_q <= 4'd0;
            total_q     <= 5'd0;
            gets_q      <= 5'd0;
            recv_q      <= 5'd0;
            drop_q      <= 5'd0;
            start_q     <= 1'b0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
            o_gen_m0    <= 4'd0;
            o_gen_mcs   <= 4'd0;
            o_gen_nslot <= 8'd0;
            o_gen_nid   <= 10'd0;
        end else begin
            start_q <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;

            if (drop_hit) begin
                drop_q <= drop_q - 5'd1;
            end
            if (gen_get) begin
                gets_q <= gets_q + 5'd1;
            end
            if (recv) begin
                recv_q <= recv_q + 5'd1;
            end

            case (state)
                S_IDLE: begin
                    if (cfg_accept) begin
                        if (cfg_bad) begin
                            err_q <= 1'b1;
                        end else begin
                            o_gen_m0    <= i_m0;
                            o_gen_mcs   <= i_mcs;
                            o_gen_nslot <= i_nslot;
                            o_gen_nid   <= i_nid;
                            start_sym_q <= i_start_sym;
                            total_q     <= cfg_sum;
                            gets_q      <= 5'd0;
                            recv_q      <= 5'd0;
                            start_q     <= 1'b1;
                            state       <= S_START;
                        end
                    end
                end
                S_START: begin
                    state <= S_RUN;
                end
                S_RUN: begin
                    if (gets_q == total_q) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (pop_last) begin
                        done_q <= 1'b1;
                        state  <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase

            // Abort: everything still in flight (including a get or receive on
            // this very edge) becomes owed to the drop counter.
            if (flush) begin
                state  <= S_IDLE;
                done_q <= 1'b0;
                drop_q <= drop_q - 5'(drop_hit) + inflight + 5'(gen_get) - 5'(recv);
                gets_q <= 5'd0;
                recv_q <= 5'd0;
            end
        end
    end

    // Output buffer: registered write of kept alphas, head drives the stream
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= 10'd0;
            end
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {i_gen_alpha, recv_q[3:0], push_last};
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    assign o_cfg_ready = (state == S_IDLE);
    assign o_gen_start = start_q;
    assign o_gen_get   = gen_get;
    assign o_valid     = (count_q != '0);
    assign o_alpha     = head[9:5];
    assign o_sym_idx   = head[4:1];
    assign o_last      = head[0];
    assign o_done      = done_q;
    assign o_err       = err_q;
    assign o_dbg_state = state;

endmodule

// File: tb/tb_pucch_alpha_scheduler.sv
// Self-checking bench for pucch_alpha_scheduler. A behavioural generator
// returns alphas in request order with random latency; the expected output
// stream of each occasion is built directly from the occasion rules.
`timescale 1ns/1ps

module tb_pucch_alpha_scheduler;

  localparam int DEPTH = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

`ifdef PUCCH_ALPHA_SCHED_ABORT_EN
  logic i_abort;
`endif
  logic       i_cfg_valid;
  logic       o_cfg_ready;
  logic [3:0] i_m0, i_mcs;
  logic [7:0] i_nslot;
  logic [9:0] i_nid;
  logic [3:0] i_start_sym, i_nsym;
  logic       o_gen_start;
  logic [3:0] o_gen_m0, o_gen_mcs;
  logic [7:0] o_gen_nslot;
  logic [9:0] o_gen_nid;
  logic       o_gen_get;
  logic       i_gen_can_get;
  logic       i_gen_valid;
  logic [4:0] i_gen_alpha;
  logic       o_valid;
  logic       i_ready;
  logic [4:0] o_alpha;
  logic [3:0] o_sym_idx;
  logic       o_last;
  logic       o_done;
  logic       o_err;
  logic [1:0] o_dbg_state;

  pucch_alpha_scheduler #(.FIFO_DEPTH(DEPTH), .NSYM_SLOT(14)) dut (
    .clk(clk),
    .rst(rst),
`ifdef PUCCH_ALPHA_SCHED_ABORT_EN
    .i_abort(i_abort),
`endif
    .i_cfg_valid(i_cfg_valid),
    .o_cfg_ready(o_cfg_ready),
    .i_m0(i_m0),
    .i_mcs(i_mcs),
    .i_nslot(i_nslot),
    .i_nid(i_nid),
    .i_start_sym(i_start_sym),
    .i_nsym(i_nsym),
    .o_gen_start(o_gen_start),
    .o_gen_m0(o_gen_m0),
    .o_gen_mcs(o_gen_mcs),
    .o_gen_nslot(o_gen_nslot),
    .o_gen_nid(o_gen_nid),
    .o_gen_get(o_gen_get),
    .i_gen_can_get(i_gen_can_get),
    .i_gen_valid(i_gen_valid),
    .i_gen_alpha(i_gen_alpha),
    .o_valid(o_valid),
    .i_ready(i_ready),
    .o_alpha(o_alpha),
    .o_sym_idx(o_sym_idx),
    .o_last(o_last),
    .o_done(o_done),
    .o_err(o_err),
    .o_dbg_state(o_dbg_state)
  );

  // ---------------- model / scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;

  logic [4:0] spec_alpha [14];
  logic [4:0] seq [14];        // generator output sequence for current occasion
  int         gen_idx;
  logic [4:0] pend_q [$];      // generator values requested, not yet returned
  logic [9:0] exp_q [$];       // expected {alpha, sym_idx, last}

  logic [3:0] cfg_m0, cfg_mcs, cfg_ss, cfg_ns;
  logic [7:0] cfg_nslot;
  logic [9:0] cfg_nid;
  bit   cfg_offer, acc_ok, acc_prev, busy, last_hs_prev, prev_stall, gen_stall, force_can;
  logic [9:0] prev_fields;
  int   start_sym_m, recv_idx, swallow_n, held, max_credit;
  int   gets_cnt, hs_cnt, done_cnt, start_cnt, err_cnt, ready_mode, occ_cyc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_ctl", 32'({o_cfg_ready, o_gen_start, o_gen_get, o_valid, o_done, o_err, o_last}), 32'h40);
    check("rst_data", 32'({o_alpha, o_sym_idx, o_dbg_state}), 32'h0);
    check("rst_gen", 32'({o_gen_m0, o_gen_mcs, o_gen_nslot, o_gen_nid}), 32'h0);
  endtask

  // ---------------- driver: one clock cycle ----------------
  task automatic tick();
    logic [9:0] got;
    logic [9:0] e;
    int cs;
    @(negedge clk);
    if (cfg_offer) begin
      i_cfg_valid = 1'b1;
      i_m0 = cfg_m0; i_mcs = cfg_mcs; i_nslot = cfg_nslot; i_nid = cfg_nid;
      i_start_sym = cfg_ss; i_nsym = cfg_ns;
    end else if (busy && ($urandom_range(0, 3) == 0)) begin
      i_cfg_valid = 1'b1;
      i_m0 = 4'($urandom_range(0, 15)); i_mcs = 4'($urandom_range(0, 15));
      i_nslot = 8'($urandom_range(0, 255)); i_nid = 10'($urandom_range(0, 1023));
      i_start_sym = 4'($urandom_range(0, 15)); i_nsym = 4'($urandom_range(0, 15));
    end else begin
      i_cfg_valid = 1'b0;
    end
    i_gen_can_get = force_can ? 1'b1 : ($urandom_range(0, 3) != 0);
    if (!gen_stall && pend_q.size() != 0 && $urandom_range(0, 2) != 0) begin
      i_gen_valid = 1'b1;
      i_gen_alpha = pend_q[0];
    end else begin
      i_gen_valid = 1'b0;
      i_gen_alpha = 5'($urandom_range(0, 31));
    end
    case (ready_mode)
      0: i_ready = 1'b1;
      1: i_ready = ($urandom_range(0, 1) == 1);
      2: i_ready = (occ_cyc < 16) ? (occ_cyc % 2 == 0) : (occ_cyc >= 36);
      default: i_ready = 1'b0;
    endcase
    occ_cyc++;
    #1;
    // results of the previous edge
    if (acc_prev) begin
      check("gen_start", 32'(o_gen_start), 32'(acc_ok));
      check("err_pulse", 32'(o_err), 32'(!acc_ok));
      if (acc_ok)
        check("gen_cfg", 32'({o_gen_m0, o_gen_mcs, o_gen_nslot, o_gen_nid}),
              32'({cfg_m0, cfg_mcs, cfg_nslot, cfg_nid}));
      acc_prev = 1'b0;
    end
    if (o_done || last_hs_prev) check("done_pulse", 32'(o_done), 32'(last_hs_prev));
    last_hs_prev = 1'b0;
    check("cfg_ready", 32'(o_cfg_ready), 32'(!busy));
    if (prev_stall) check("stable", 32'({o_valid, o_alpha, o_sym_idx, o_last}), 32'({1'b1, prev_fields}));
    if (o_gen_start) begin start_cnt++; gen_idx = 0; end
    if (o_err) err_cnt++;
    cs = held + pend_q.size() - swallow_n;
    if (cs > max_credit) max_credit = cs;
    // events at the coming edge
    if (cfg_offer && o_cfg_ready) begin
      acc_prev = 1'b1;
      cfg_offer = 1'b0;
      if (acc_ok) busy = 1'b1;
    end
    if (i_gen_valid) begin
      void'(pend_q.pop_front());
      if (swallow_n > 0) swallow_n--;
      else begin
        if (recv_idx >= start_sym_m) held++;
        recv_idx++;
      end
    end
    if (o_gen_get) begin
      gets_cnt++;
      pend_q.push_back(gen_idx < 14 ? seq[gen_idx] : 5'd0);
      gen_idx++;
    end
    if (o_valid && i_ready) begin
      hs_cnt++;
      got = {o_alpha, o_sym_idx, o_last};
      check("out_avail", 32'(exp_q.size() != 0), 32'h1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("out_beat", 32'(got), 32'(e));
        held--;
        if (e[0]) begin last_hs_prev = 1'b1; busy = 1'b0; end
      end
    end
    prev_stall = o_valid && !i_ready;
    prev_fields = {o_alpha, o_sym_idx, o_last};
  endtask

  // ---------------- occasion driver + reference model ----------------
  task automatic run_occasion(input int ss, input int ns, input bit use_spec, input int rmode, input int stop_after);
    bit stop;
    stop = 1'b0;
    for (int i = 0; i < 14; i++) seq[i] = use_spec ? spec_alpha[i] : 5'($urandom_range(0, 11));
    if (use_spec) begin
      cfg_m0 = 4'd5; cfg_mcs = 4'd0; cfg_nslot = 8'd3; cfg_nid = 10'd512;
    end else begin
      cfg_m0 = 4'($urandom_range(0, 11)); cfg_mcs = 4'($urandom_range(0, 11));
      cfg_nslot = 8'($urandom_range(0, 159)); cfg_nid = 10'($urandom_range(0, 1023));
    end
    cfg_ss = 4'(ss); cfg_ns = 4'(ns);
    exp_q.delete();
    for (int s = ss; s < ss + ns; s++) exp_q.push_back({seq[s], 4'(s), (s == ss + ns - 1)});
    start_sym_m = ss; recv_idx = 0; held = 0; max_credit = 0;
    gets_cnt = 0; hs_cnt = 0; done_cnt = 0; start_cnt = 0; err_cnt = 0;
    ready_mode = rmode; occ_cyc = 0; acc_ok = 1'b1; cfg_offer = 1'b1;
    for (int n = 0; n < 800 && !stop; n++) begin
      tick();
      if (o_done) done_cnt++;
      if (done_cnt != 0) stop = 1'b1;
      if (stop_after > 0 && hs_cnt >= stop_after) stop = 1'b1;
    end
    check("occ_timeout", 32'(stop), 32'h1);
    if (stop_after == 0) begin
      check("occ_done_cnt", 32'(done_cnt), 32'h1);
      check("occ_gets", 32'(gets_cnt), 32'(ss + ns));
      check("occ_outputs", 32'(hs_cnt), 32'(ns));
      check("occ_exp_left", 32'(exp_q.size()), 32'h0);
      check("occ_starts", 32'(start_cnt), 32'h1);
      check("occ_credit", 32'(max_credit <= DEPTH), 32'h1);
    end
  endtask

  task automatic bad_cfg(input int ss, input int ns);
    cfg_m0 = 4'd5; cfg_mcs = 4'd0; cfg_nslot = 8'd3; cfg_nid = 10'd512;
    cfg_ss = 4'(ss); cfg_ns = 4'(ns);
    acc_ok = 1'b0; cfg_offer = 1'b1; err_cnt = 0; start_cnt = 0; ready_mode = 0;
    repeat (5) tick();
    check("bad_err_cnt", 32'(err_cnt), 32'h1);
    check("bad_no_start", 32'(start_cnt), 32'h0);
  endtask

  task automatic clear_model();
    pend_q.delete(); exp_q.delete();
    held = 0; swallow_n = 0; busy = 1'b0; acc_prev = 1'b0; cfg_offer = 1'b0;
    last_hs_prev = 1'b0; prev_stall = 1'b0; gen_stall = 1'b0; force_can = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    spec_alpha = '{5'd4, 5'd4, 5'd0, 5'd11, 5'd5, 5'd7, 5'd8, 5'd11, 5'd3, 5'd10, 5'd10, 5'd6, 5'd1, 5'd10};
    rst = 1'b0;
`ifdef PUCCH_ALPHA_SCHED_ABORT_EN
    i_abort = 1'b0;
`endif
    i_cfg_valid = 1'b0; i_m0 = '0; i_mcs = '0; i_nslot = '0; i_nid = '0;
    i_start_sym = '0; i_nsym = '0; i_gen_can_get = 1'b0; i_gen_valid = 1'b0;
    i_gen_alpha = '0; i_ready = 1'b0;
    gen_idx = 0; ready_mode = 0; occ_cyc = 0; start_sym_m = 0; recv_idx = 0;
    gets_cnt = 0; hs_cnt = 0; done_cnt = 0; start_cnt = 0; err_cnt = 0; max_credit = 0;
    acc_ok = 1'b1; prev_fields = '0;
    clear_model();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    @(negedge clk);
    rst = 1'b1;

    // full slot, always ready
    run_occasion(0, 14, 1'b1, 0, 0);
    // partial occasion: first 10 values dropped
    run_occasion(10, 4, 1'b1, 0, 0);
    // backpressure: alternate, then stall 20 cycles
    run_occasion(0, 14, 1'b1, 2, 0);
    // rejected configs
    bad_cfg(12, 4);
    bad_cfg(3, 0);
    bad_cfg(13, 2);

    // asynchronous reset in the middle of an occasion
    run_occasion(0, 14, 1'b1, 0, 5);
    #2;
    rst = 1'b0;
    #1;
    check_reset_outputs();
    i_cfg_valid = 1'b0; i_gen_valid = 1'b0;
    clear_model();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    run_occasion(0, 14, 1'b1, 0, 0);

`ifdef PUCCH_ALPHA_SCHED_ABORT_EN
    // abort with values outstanding, then a short occasion
    run_occasion(0, 14, 1'b1, 0, 3);
    ready_mode = 3; gen_stall = 1'b1; force_can = 1'b1;
    repeat (6) tick();
    check("abort_credit", 32'(held + pend_q.size()), 32'(DEPTH));
    i_abort = 1'b1;
    swallow_n = pend_q.size();
    exp_q.delete(); held = 0; busy = 1'b0; last_hs_prev = 1'b0; prev_stall = 1'b0;
    @(posedge clk);
    #1;
    i_abort = 1'b0;
    gen_stall = 1'b0; force_can = 1'b0; ready_mode = 0;
    tick();
    check("abort_valid", 32'(o_valid), 32'h0);
    tick();
    run_occasion(0, 2, 1'b1, 0, 0);
`endif

    // randomized occasions, mixed with rejected configs
    for (int k = 0; k < 8; k++) begin
      int ss;
      int ns;
      ss = $urandom_range(0, 13);
      ns = $urandom_range(1, 14 - ss);
      run_occasion(ss, ns, 1'b0, 1, 0);
      if (k % 3 == 1) bad_cfg(ss, 15 - ss);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
